// File: rtl/io_pkg.sv
// Shared types and default sizing for the I/O and interrupt front end.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SVC
    } io_int_state_t;

    localparam int unsigned IO_DATA_WIDTH  = 16;
    localparam int unsigned IO_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for asynchronous inputs, cleared to zero on reset.
module sync_ff #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/io_interrupt_ctrl.sv
// External I/O front end: input synchronization, interrupt request/acknowledge
// sequencing with one queued interrupt and a saturating miss counter, and the output port.
module io_interrupt_ctrl
    import io_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = IO_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = IO_SYNC_STAGES,
    parameter int unsigned MISS_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  int_pin,
    input  logic [DATA_WIDTH-1:0] port_in_pin,
    output logic [DATA_WIDTH-1:0] in_data,
    input  logic                  out_wr,
    input  logic [DATA_WIDTH-1:0] out_data,
    output logic [DATA_WIDTH-1:0] port_out,
    output logic                  int_req,
    input  logic                  int_ack,
    input  logic                  rti,
    output logic                  int_pending,
    output logic [MISS_WIDTH-1:0] miss_cnt
);

    localparam logic [MISS_WIDTH-1:0] MissMax = '1;

    io_int_state_t         state_q, state_d;
    logic                  pending_q, pending_d;
    logic [MISS_WIDTH-1:0] miss_q, miss_d;
    logic [DATA_WIDTH-1:0] port_out_q;
    logic                  int_sync, int_prev_q, int_evt;

    sync_ff #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync_bus (
        .clk   (clk),
        .reset (reset),
        .d     (port_in_pin),
        .q     (in_data)
    );

    sync_ff #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_sync_int (
        .clk   (clk),
        .reset (reset),
        .d     (int_pin),
        .q     (int_sync)
    );

    assign int_evt = int_sync & ~int_prev_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        miss_d    = miss_q;

        case (state_q)
            IDLE:    if (int_evt) state_d = REQ;
            REQ:     if (int_ack) state_d = SVC;
            SVC:     if (rti) state_d = (pending_q || int_evt) ? REQ : IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q == SVC && rti) begin
            // A coincident edge either goes straight to service or replaces the consumed one.
            pending_d = pending_q & int_evt;
        end else if (state_q != IDLE && int_evt) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else if (miss_q != MissMax) begin
                miss_d = miss_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            miss_q     <= '0;
            int_prev_q <= 1'b0;
            port_out_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            miss_q     <= miss_d;
            int_prev_q <= int_sync;
            if (out_wr) begin
                port_out_q <= out_data;
            end
        end
    end

    assign int_req     = (state_q == REQ);
    assign int_pending = pending_q;
    assign miss_cnt    = miss_q;
    assign port_out    = port_out_q;

endmodule

// File: tb/tb_io_interrupt_ctrl.sv
// Directed self-checking bench for io_interrupt_ctrl.
module tb_io_interrupt_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        int_pin;
    logic [15:0] port_in_pin;
    logic [15:0] in_data;
    logic        out_wr;
    logic [15:0] out_data;
    logic [15:0] port_out;
    logic        int_req;
    logic        int_ack;
    logic        rti;
    logic        int_pending;
    logic [3:0]  miss_cnt;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    io_interrupt_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .int_pin     (int_pin),
        .port_in_pin (port_in_pin),
        .in_data     (in_data),
        .out_wr      (out_wr),
        .out_data    (out_data),
        .port_out    (port_out),
        .int_req     (int_req),
        .int_ack     (int_ack),
        .rti         (rti),
        .int_pending (int_pending),
        .miss_cnt    (miss_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
    endtask

    // Two cycles high then two low: one synchronized rising edge, acted on at the third edge.
    task automatic pulse_int();
        int_pin = 1'b1;
        tick();
        tick();
        int_pin = 1'b0;
        tick();
        tick();
    endtask

    task automatic strobe_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic strobe_rti();
        rti = 1'b1;
        tick();
        rti = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        int_pin     = 1'b0;
        port_in_pin = 16'h00F0;
        out_wr      = 1'b0;
        out_data    = 16'h0000;
        int_ack     = 1'b0;
        rti         = 1'b0;
        tick();
        tick();
        total_cnt++;
        if ({in_data, port_out, int_req, int_pending, miss_cnt} !== 38'd0)
            $display("FAIL reset_outputs got in=%h out=%h req=%b pend=%b miss=%0d want all 0",
                     in_data, port_out, int_req, int_pending, miss_cnt);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        total_cnt++;
        if (in_data !== 16'h0000) $display("FAIL in_data_edge1 got %h want 0000", in_data);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (in_data !== 16'h00F0) $display("FAIL in_data_edge2 got %h want 00f0", in_data);
        else pass_cnt++;
    endtask

    task automatic test_single();
        int_pin = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (int_req !== 1'b0) $display("FAIL single_req_edge2 got %b want 0", int_req);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (int_req !== 1'b1) $display("FAIL single_req_edge3 got %b want 1", int_req);
        else pass_cnt++;
        tick();
        strobe_ack();
        total_cnt++;
        if (int_req !== 1'b0) $display("FAIL single_req_after_ack got %b want 0", int_req);
        else pass_cnt++;
        tick();
        int_pin = 1'b0;
        total_cnt++;
        if (int_pending !== 1'b0) $display("FAIL single_held_pin_pending got %b want 0", int_pending);
        else pass_cnt++;
        strobe_rti();
        tick();
        total_cnt++;
        if ({int_req, int_pending} !== 2'b00)
            $display("FAIL single_after_rti got req=%b pend=%b want 0 0", int_req, int_pending);
        else pass_cnt++;
        strobe_ack();
        tick();
        total_cnt++;
        if (int_req !== 1'b0) $display("FAIL ack_in_idle got req=%b want 0", int_req);
        else pass_cnt++;
    endtask

    task automatic test_nested();
        do_reset();
        pulse_int();
        total_cnt++;
        if (int_req !== 1'b1) $display("FAIL nested_req got %b want 1", int_req);
        else pass_cnt++;
        strobe_ack();
        pulse_int();
        total_cnt++;
        if ({int_pending, miss_cnt} !== 5'b1_0000)
            $display("FAIL nested_pending got pend=%b miss=%0d want 1 0", int_pending, miss_cnt);
        else pass_cnt++;
        repeat (3) pulse_int();
        total_cnt++;
        if (miss_cnt !== 4'd3) $display("FAIL nested_miss3 got %0d want 3", miss_cnt);
        else pass_cnt++;
        repeat (20) pulse_int();
        total_cnt++;
        if ({int_req, miss_cnt} !== 5'b0_1111)
            $display("FAIL nested_miss_sat got req=%b miss=%0d want 0 15", int_req, miss_cnt);
        else pass_cnt++;
        strobe_rti();
        total_cnt++;
        if ({int_req, int_pending, miss_cnt} !== 6'b10_1111)
            $display("FAIL nested_rti_rereq got req=%b pend=%b miss=%0d want 1 0 15",
                     int_req, int_pending, miss_cnt);
        else pass_cnt++;
        strobe_ack();
        strobe_rti();
        tick();
        total_cnt++;
        if (int_req !== 1'b0) $display("FAIL nested_final_idle got req=%b want 0", int_req);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        pulse_int();
        strobe_ack();
        // Edge lands on the same clock as rti, no interrupt pending.
        int_pin = 1'b1;
        tick();
        tick();
        strobe_rti();
        int_pin = 1'b0;
        total_cnt++;
        if ({int_req, int_pending, miss_cnt} !== 6'b10_0000)
            $display("FAIL sim_rti_nopend got req=%b pend=%b miss=%0d want 1 0 0",
                     int_req, int_pending, miss_cnt);
        else pass_cnt++;
        tick();
        strobe_ack();
        tick();
        pulse_int();
        pulse_int();
        total_cnt++;
        if ({int_pending, miss_cnt} !== 5'b1_0001)
            $display("FAIL sim_setup got pend=%b miss=%0d want 1 1", int_pending, miss_cnt);
        else pass_cnt++;
        // Edge with rti while one is pending: it replaces the consumed one.
        int_pin = 1'b1;
        tick();
        tick();
        strobe_rti();
        int_pin = 1'b0;
        total_cnt++;
        if ({int_req, int_pending, miss_cnt} !== 6'b11_0001)
            $display("FAIL sim_rti_pend got req=%b pend=%b miss=%0d want 1 1 1",
                     int_req, int_pending, miss_cnt);
        else pass_cnt++;
        tick();
        strobe_ack();
        strobe_rti();
        total_cnt++;
        if ({int_req, int_pending} !== 2'b10)
            $display("FAIL sim_drain got req=%b pend=%b want 1 0", int_req, int_pending);
        else pass_cnt++;
        tick();
        // Edge coincident with the acknowledge queues as pending.
        int_pin = 1'b1;
        tick();
        tick();
        strobe_ack();
        int_pin = 1'b0;
        total_cnt++;
        if ({int_req, int_pending, miss_cnt} !== 6'b01_0001)
            $display("FAIL sim_ack_edge got req=%b pend=%b miss=%0d want 0 1 1",
                     int_req, int_pending, miss_cnt);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_output();
        out_data = 16'h002D;
        tick();
        total_cnt++;
        if (port_out !== 16'h0000) $display("FAIL out_no_strobe got %h want 0000", port_out);
        else pass_cnt++;
        out_wr = 1'b1;
        tick();
        out_wr = 1'b0;
        total_cnt++;
        if (port_out !== 16'h002D) $display("FAIL out_write got %h want 002d", port_out);
        else pass_cnt++;
        out_data = 16'h003A;
        tick();
        tick();
        total_cnt++;
        if (port_out !== 16'h002D) $display("FAIL out_hold got %h want 002d", port_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        // Enters with int_pending=1, miss_cnt=1 and SVC from the simultaneous test.
        pulse_int();
        int_pin = 1'b1;
        tick();
        total_cnt++;
        if ({int_pending, miss_cnt} !== 5'b1_0010)
            $display("FAIL mid_setup got pend=%b miss=%0d want 1 2", int_pending, miss_cnt);
        else pass_cnt++;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({in_data, port_out, int_req, int_pending, miss_cnt} !== 38'd0)
            $display("FAIL mid_reset_clear got in=%h out=%h req=%b pend=%b miss=%0d want all 0",
                     in_data, port_out, int_req, int_pending, miss_cnt);
        else pass_cnt++;
        tick();
        reset = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (int_req !== 1'b0) $display("FAIL mid_req_edge2 got %b want 0", int_req);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (int_req !== 1'b1) $display("FAIL mid_req_edge3 got %b want 1", int_req);
        else pass_cnt++;
        int_pin = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_nested();
        test_simultaneous();
        test_output();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/io_interrupt_ctrl.md
# io_interrupt_ctrl

External I/O front end for the pipeline processor: conditions the raw `portIn` bus and `int` pin before they reach the core, and registers the core's `OUT` writes onto the external `portOut` bus. It synchronizes asynchronous inputs and turns the interrupt pin into a single request/acknowledge transaction. It also tracks one further interrupt that arrives while another is being serviced.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of the input and output port buses.
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronizers; minimum 2.
- `MISS_WIDTH`, 4: width of the saturating missed-interrupt counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `int_pin`  in  1  external interrupt pin; asynchronous, level, rising-edge significant.
- `port_in_pin`  in  DATA_WIDTH  external input bus; asynchronous.
- `in_data`  out  DATA_WIDTH  synchronized input bus, read by the core's `IN` instruction.
- `out_wr`  in  1  one-cycle strobe from the core's `OUT` instruction.
- `out_data`  in  DATA_WIDTH  value to drive externally.
- `port_out`  out  DATA_WIDTH  registered external output bus.
- `int_req`  out  1  interrupt request to the core.
- `int_ack`  in  1  core accepted the request and entered the handler.
- `rti`  in  1  one-cycle strobe when the core retires `RTI`.
- `int_pending`  out  1  a second interrupt is queued.
- `miss_cnt`  out  MISS_WIDTH  count of dropped interrupts; saturates at the maximum value.

## Operation
- Input bus: `port_in_pin` passes through a `SYNC_STAGES`-deep synchronizer. `in_data` is the final stage.
- Interrupt edge: `int_pin` is synchronized, then rising-edge detected against the previous synchronized value. An edge produces a one-cycle internal `int_evt`.
- FSM states:
  - **IDLE**: `int_req=0`. On `int_evt`, go to REQ.
  - **REQ**: `int_req=1`. On `int_ack=1`, go to SVC.
  - **SVC**: `int_req=0`. On `rti=1`, go to REQ if `int_pending`, else go to IDLE. Leaving SVC for REQ clears `int_pending`.
- `int_evt` while in REQ or SVC:
  - If `int_pending=0`, it sets `int_pending`.
  - If `int_pending=1`, it increments `miss_cnt`, which saturates at 2^MISS_WIDTH−1.
- Ignored strobes:
  - `int_ack` outside REQ.
  - `rti` outside SVC.
- Simultaneous events:
  - `int_evt` and `rti` in SVC with `int_pending=0`: next state is REQ and `int_pending` stays 0. The new edge is serviced immediately.
  - `int_evt` and `rti` in SVC with `int_pending=1`: next state is REQ, `int_pending` stays 1 (the new edge replaces the consumed one), and `miss_cnt` is unchanged.
  - `int_evt` and `int_ack` in REQ: go to SVC and apply the pending rule to the edge.
- Output port: `out_wr=1` loads `out_data` into `port_out`. Otherwise `port_out` holds its value.

## Timing
- Reset values (asynchronous):
  - all synchronizer flops, `in_data`, `port_out`, `int_pending`, `miss_cnt` = 0;
  - `int_req` = 0; FSM = IDLE.
- Input latency:
  - `in_data` reflects `port_in_pin` after `SYNC_STAGES` rising edges.
  - `int_req` rises `SYNC_STAGES+1` edges after `int_pin` rises, measured from IDLE with setup met.
- Handshake:
  - `int_req` falls on the edge that samples `int_ack=1`.
  - With `int_pending=1`, `int_req` re-rises on the edge that samples `rti=1`.
- `port_out` updates on the edge sampling `out_wr`; write latency is 1 cycle.
- A pin held high produces one event only; it must go low and return high to produce another.
- Reset mid-operation:
  - The FSM aborts and any pending interrupt is lost.
  - If `int_pin` is high when `reset` releases, the zeroed synchronizer sees a rising edge, and a request follows after `SYNC_STAGES+1` edges.

## Structure
- Package `io_pkg` holds:
  - state enum `io_int_state_t` = {IDLE, REQ, SVC};
  - default constants `IO_DATA_WIDTH=16`, `IO_SYNC_STAGES=2`.
- Sub-module `sync_ff` (parameters `WIDTH`, `STAGES`; asynchronous active-low reset to 0) is instantiated twice:
  - once for the bus, at width `DATA_WIDTH`;
  - once for the interrupt pin, at width 1.
- Edge detect, FSM, counter and output register live in the top level.

## Test plan
- Reset release with `port_in_pin=16'h00F0`: all outputs 0 during reset; `in_data=16'h00F0` exactly 2 edges after release.
- Single interrupt: `int_pin` high for 6 cycles → `int_req=1` at edge 3; `int_ack` at edge 5 → `int_req=0`; `rti` → IDLE with `int_pending=0`.
- Nested edges: 1 edge in SVC → `int_pending=1`. Then 3 more edges → `miss_cnt=3`; 20 more edges → `miss_cnt=15` and holds. On `rti`, `int_req` rises on the same edge.
- Simultaneous edge and `rti` with no pending interrupt: next state REQ, `int_pending=0`, `miss_cnt` unchanged.
- Output port: `out_wr` with `out_data=16'h002D` → `port_out=16'h002D` one edge later; it holds when `out_data` changes to `16'h003A` without a strobe.
- Reset mid-SVC with `int_pending=1` and `int_pin` held high: everything clears on assert; after release, `int_req` rises 3 edges later.
